// File: rtl/bcd_alu_seq.sv
// bcd_alu_seq: digit-serial sign-magnitude BCD add/subtract unit.
//
// The operands are DIGITS BCD digits plus a sign bit (MSB, 1 = negative).
// They are latched from a shared bus and combined one digit per clock,
// least-significant digit first. A negative magnitude difference is turned
// back into a positive magnitude by a second digit-serial pass (10's complement).
//
// Optional feature macro: BCD_ALU_DIGIT_CHECK_EN. When it is defined, the
// `err` port exists and non-BCD operand digits are rejected when a start is accepted.
//
// Ports:
//   clk        system clock, rising edge
//   nrst       asynchronous active-low reset
//   op         shared operand bus (W = 4*DIGITS+1)
//   assign_op1 load op into operand A (IDLE only)
//   assign_op2 load op into operand B (IDLE only)
//   opcode     3'b001 = A+B, 3'b010 = A-B, all other codes are ignored
//   start      begin an operation on the latched A and B
//   busy       operation in progress (ADD, COMP, DONE)
//   done       one-cycle completion pulse
//   result     sign-magnitude BCD result, held until the next done
//   o_flag     magnitude overflow on an add
//   sign       result sign, equal to result[W-1]
//   err        non-BCD operand detected (BCD_ALU_DIGIT_CHECK_EN only)
//
// state  | meaning
// IDLE   | waiting for start; operand strobes are honoured
// ADD    | one digit per cycle of |A| +/- |B|
// COMP   | 10's complement of a negative difference, one digit per cycle
// DONE   | outputs updated, done pulse
module bcd_alu_seq #(
  parameter int DIGITS = 4
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [4*DIGITS:0] op,
  input  logic              assign_op1,
  input  logic              assign_op2,
  input  logic [2:0]        opcode,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [4*DIGITS:0] result,
  output logic              o_flag,
  output logic              sign
`ifdef BCD_ALU_DIGIT_CHECK_EN
  ,output logic             err
`endif
);

  localparam int M  = 4*DIGITS;
  localparam int CW = $clog2(DIGITS+1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DIGITS-1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_COMP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state;
  logic [M:0]    a_reg, b_reg;
  logic [M-1:0]  a_sh, b_sh, acc;
  logic [CW-1:0] cnt;
  logic          carry, sub_mag, s_a;

  logic          op_legal, accept, eff_sub, last, mag_zero, cout;
  logic [3:0]    x_d, y_d, sum_d;
  logic [4:0]    bin;
  logic [M+3:0]  shifted;
  logic [M-1:0]  acc_nxt;

  assign op_legal = (opcode == 3'b001) || (opcode == 3'b010);
  assign accept   = (state == S_IDLE) && start && op_legal;
  // Magnitudes are subtracted when the signs differ once B's sign has been
  // flipped for a subtract opcode.
  assign eff_sub  = a_reg[M] ^ b_reg[M] ^ (opcode == 3'b010);
  assign last     = (cnt == '0);

  // One BCD digit adder shared by ADD and COMP. In COMP the stored magnitude
  // goes through 9's complement plus the preset carry, which gives the
  // 10's complement.
  always_comb begin
    x_d = a_sh[3:0];
    y_d = sub_mag ? (4'd9 - b_sh[3:0]) : b_sh[3:0];
    if (state == S_COMP) begin
      x_d = 4'd9 - acc[3:0];
      y_d = 4'd0;
    end
    bin   = {1'b0, x_d} + {1'b0, y_d} + {4'b0, carry};
    cout  = (bin > 5'd9);
    sum_d = cout ? (bin[3:0] + 4'd6) : bin[3:0];
  end

  // The new digit enters at the top, so after DIGITS shifts the LSD is back at bit 0.
  assign shifted  = {sum_d, acc};
  assign acc_nxt  = shifted[M+3:4];
  assign mag_zero = (acc_nxt == '0);

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);
  assign sign = result[M];

`ifdef BCD_ALU_DIGIT_CHECK_EN
  function automatic logic has_bad(input logic [M-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < DIGITS; k++)
      if (v[4*k +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= S_IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      acc     <= '0;
      cnt     <= '0;
      carry   <= 1'b0;
      sub_mag <= 1'b0;
      s_a     <= 1'b0;
      result  <= '0;
      o_flag  <= 1'b0;
`ifdef BCD_ALU_DIGIT_CHECK_EN
      err     <= 1'b0;
`endif
    end else begin
      if (state == S_IDLE) begin
        if (assign_op1) a_reg <= op;
        if (assign_op2) b_reg <= op;
      end
      case (state)
        S_IDLE: begin
          if (accept) begin
            a_sh    <= a_reg[M-1:0];
            b_sh    <= b_reg[M-1:0];
            acc     <= '0;
            cnt     <= CNT_LOAD;
            sub_mag <= eff_sub;
            carry   <= eff_sub;  // the +1 of |A| + 9's complement(|B|) + 1
            s_a     <= a_reg[M];
`ifdef BCD_ALU_DIGIT_CHECK_EN
            if (has_bad(a_reg[M-1:0]) || has_bad(b_reg[M-1:0])) begin
              state  <= S_DONE;
              result <= '0;
              o_flag <= 1'b0;
              err    <= 1'b1;
            end else begin
              state <= S_ADD;
            end
`else
            state <= S_ADD;
`endif
          end
        end
        S_ADD: begin
          a_sh  <= a_sh >> 4;
          b_sh  <= b_sh >> 4;
          acc   <= acc_nxt;
          carry <= cout;
          cnt   <= cnt - 1'b1;
          if (last) begin
            if (sub_mag && !cout) begin
              // |A| < |B|: the sum is the complement of the true magnitude.
              state <= S_COMP;
              cnt   <= CNT_LOAD;
              carry <= 1'b1;
            end else begin
              state            <= S_DONE;
              result[M-1:0]    <= acc_nxt;
              if (!sub_mag && cout) begin
                o_flag    <= 1'b1;
                result[M] <= 1'b0;
              end else begin
                o_flag    <= 1'b0;
                result[M] <= s_a & ~mag_zero;
              end
`ifdef BCD_ALU_DIGIT_CHECK_EN
              err <= 1'b0;
`endif
            end
          end
        end
        S_COMP: begin
          acc   <= acc_nxt;
          carry <= cout;
          cnt   <= cnt - 1'b1;
          if (last) begin
            state  <= S_DONE;
            result <= {~s_a & ~mag_zero, acc_nxt};
            o_flag <= 1'b0;
`ifdef BCD_ALU_DIGIT_CHECK_EN
            err    <= 1'b0;
`endif
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_alu_seq.sv
module tb_bcd_alu_seq;
  localparam int DIGITS = 4;
  localparam int W = 4*DIGITS+1;

  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic [W-1:0] op = '0;
  logic         assign_op1 = 1'b0;
  logic         assign_op2 = 1'b0;
  logic [2:0]   opcode = 3'b000;
  logic         start = 1'b0;
  logic         busy, done, o_flag, sign;
  logic [W-1:0] result;
`ifdef BCD_ALU_DIGIT_CHECK_EN
  logic         err;
`endif

  bcd_alu_seq #(.DIGITS(DIGITS)) dut (
    .clk(clk), .nrst(nrst), .op(op), .assign_op1(assign_op1), .assign_op2(assign_op2),
    .opcode(opcode), .start(start), .busy(busy), .done(done), .result(result),
    .o_flag(o_flag), .sign(sign)
`ifdef BCD_ALU_DIGIT_CHECK_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [2:0] ADD = 3'b001;
  localparam logic [2:0] SUB = 3'b010;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk); op = a; assign_op1 = 1'b1;
    @(negedge clk); assign_op1 = 1'b0; op = b; assign_op2 = 1'b1;
    @(negedge clk); assign_op2 = 1'b0;
  endtask

  // Called at the negedge inside cycle `first`; returns the cycle in which
  // done was seen, or -1 when the budget runs out.
  task automatic wait_done(input int first, output int cyc);
    cyc = -1;
    for (int n = first; n <= 40; n++) begin
      if (done) begin cyc = n; break; end
      @(negedge clk);
    end
  endtask

  task automatic run_op(input logic [2:0] opc, output int cyc, output logic busy1);
    @(negedge clk); opcode = opc; start = 1'b1;
    @(negedge clk); start = 1'b0;
    busy1 = busy;
    wait_done(1, cyc);
  endtask

  int   cyc;
  logic b1;
  logic seen;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_result", 32'(result), 32'h0);
    check("rst_flags", {busy, done, o_flag, sign}, 32'h0);
    nrst = 1'b1;

    load({1'b0, 16'h1234}, {1'b0, 16'h0766});
    run_op(ADD, cyc, b1);
    check("add_cycle", cyc, 5);
    check("add_busy_c1", 32'(b1), 32'h1);
    check("add_result", 32'(result), {15'h0, 1'b0, 16'h2000});
    check("add_oflag", 32'(o_flag), 32'h0);
    check("add_busy_done", 32'(busy), 32'h1);
    @(negedge clk);
    check("add_after_done", {busy, done}, 32'h0);

    load({1'b0, 16'h0100}, {1'b0, 16'h0250});
    run_op(SUB, cyc, b1);
    check("sub_neg_cycle", cyc, 9);
    check("sub_neg_result", 32'(result), {15'h0, 1'b1, 16'h0150});
    check("sub_neg_sign", 32'(sign), 32'h1);

    load({1'b0, 16'h9999}, {1'b0, 16'h0001});
    run_op(ADD, cyc, b1);
    check("ovf_cycle", cyc, 5);
    check("ovf_result", 32'(result), 32'h0);
    check("ovf_flag", 32'(o_flag), 32'h1);

    load({1'b1, 16'h0025}, {1'b1, 16'h0025});
    run_op(SUB, cyc, b1);
    check("negzero_cycle", cyc, 5);
    check("negzero_result", 32'(result), 32'h0);
    check("negzero_flags", {o_flag, sign}, 32'h0);

    load({1'b1, 16'h0300}, {1'b0, 16'h0100});
    run_op(ADD, cyc, b1);
    check("mixed_pos_carry", cyc, 5);
    check("mixed_result1", 32'(result), {15'h0, 1'b1, 16'h0200});

    load({1'b1, 16'h0050}, {1'b0, 16'h0070});
    run_op(ADD, cyc, b1);
    check("mixed_comp_cycle", cyc, 9);
    check("mixed_result2", 32'(result), {15'h0, 1'b0, 16'h0020});

    // Illegal opcodes never start an operation and leave the outputs alone.
    seen = 1'b0;
    @(negedge clk); opcode = 3'b000; start = 1'b1;
    @(negedge clk); opcode = 3'b011;
    @(negedge clk); start = 1'b0;
    repeat (6) begin
      seen = seen | busy | done;
      @(negedge clk);
    end
    check("illegal_no_busy", 32'(seen), 32'h0);
    check("illegal_hold", 32'(result), {15'h0, 1'b0, 16'h0020});

    // A strobe while busy must not change A.
    load({1'b0, 16'h0005}, {1'b0, 16'h0003});
    @(negedge clk); opcode = ADD; start = 1'b1;
    @(negedge clk); start = 1'b0; op = {1'b0, 16'h0900}; assign_op1 = 1'b1;
    @(negedge clk); assign_op1 = 1'b0;
    wait_done(2, cyc);
    check("busy_strobe_cycle", cyc, 5);
    check("busy_strobe_res", 32'(result), {15'h0, 1'b0, 16'h0008});
    run_op(ADD, cyc, b1);
    check("a_unchanged", 32'(result), {15'h0, 1'b0, 16'h0008});

    // start and assign_op1 on the same edge: old A used, new A stored.
    @(negedge clk); op = {1'b0, 16'h0100}; assign_op1 = 1'b1; opcode = ADD; start = 1'b1;
    @(negedge clk); assign_op1 = 1'b0; start = 1'b0;
    wait_done(1, cyc);
    check("coincide_old_a", 32'(result), {15'h0, 1'b0, 16'h0008});
    run_op(ADD, cyc, b1);
    check("coincide_new_a", 32'(result), {15'h0, 1'b0, 16'h0103});

    // Reset in cycle 3 of an operation.
    @(negedge clk); opcode = ADD; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b0;
    #1;
    check("midrst_result", 32'(result), 32'h0);
    check("midrst_flags", {busy, done, o_flag, sign}, 32'h0);
    seen = 1'b0;
    repeat (3) begin @(negedge clk); seen = seen | done; end
    nrst = 1'b1;
    repeat (8) begin @(negedge clk); seen = seen | done | busy; end
    check("midrst_no_done", 32'(seen), 32'h0);
    load({1'b0, 16'h0042}, {1'b0, 16'h0058});
    run_op(ADD, cyc, b1);
    check("post_rst_cycle", cyc, 5);
    check("post_rst_result", 32'(result), {15'h0, 1'b0, 16'h0100});

`ifdef BCD_ALU_DIGIT_CHECK_EN
    load({1'b0, 16'h00A1}, {1'b0, 16'h0001});
    run_op(ADD, cyc, b1);
    check("bad_digit_cycle", cyc, 1);
    check("bad_digit_err", 32'(err), 32'h1);
    check("bad_digit_result", 32'(result), 32'h0);
    load({1'b0, 16'h0001}, {1'b0, 16'h0001});
    run_op(ADD, cyc, b1);
    check("err_cleared", 32'(err), 32'h0);
    check("valid_after_err", 32'(result), {15'h0, 1'b0, 16'h0002});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
